// File: rtl/col_sum_norm_16.sv
// ---------------------------------------------------------------------------
// col_sum_norm_16
//
// Streaming carry normalizer for the output end of the column adder tree.
// Column sums arrive least-significant column first. Each sum is added to the
// running inter-column carry. The low DIGIT_W bits leave as a canonical
// radix-2^16 digit, and the upper bits become the carry into the next column.
// After the most-significant column, one extra "flush" digit carries the
// residual carry out, so every frame yields N_COLS+1 output beats.
//
// Ports:
//   clk_sq     in   single clock, rising edge
//   reset_sq   in   synchronous, active-high reset
//   in_valid   in   column sum present
//   in_ready   out  column sum accepted this cycle (combinational on out_ready)
//   in_sum     in   unsigned column sum, SUM_W bits
//   in_last    in   marks the most-significant column of the frame
//   out_valid  out  digit present
//   out_ready  in   downstream accepts the digit
//   out_digit  out  normalized digit, DIGIT_W bits
//   out_last   out  marks the flush (carry) digit
//   len_err    out  sticky framing error
//
// Optional feature (macro COL_NORM_LEN_CHECK_EN):
//   When this macro is defined, a column counter checks the frame length.
//   If in_last arrives at the wrong column, or the frame runs past N_COLS
//   beats, len_err sets. In the run-past case, a flush is forced.
//   When the macro is undefined, no counter is built, len_err is tied 0,
//   and framing follows in_last only.
// ---------------------------------------------------------------------------
module col_sum_norm_16 #(
  parameter int SUM_W   = 26,
  parameter int DIGIT_W = 16,
  parameter int N_COLS  = 66
) (
  input  logic               clk_sq,
  input  logic               reset_sq,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SUM_W-1:0]   in_sum,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIGIT_W-1:0] out_digit,
  output logic               out_last,
  output logic               len_err
);

  // acc = in_sum + carry fits in SUM_W+1 bits, so the carry is whatever
  // remains above the digit.
  localparam int CARRY_W = SUM_W + 1 - DIGIT_W;

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t             state;
  logic [CARRY_W-1:0] carry;
  logic [SUM_W:0]     acc;
  logic               out_free;
  logic               in_fire;
  logic               end_frame;

  // The output register can take a new digit when it is empty, or when its
  // current digit leaves this cycle. This gives full throughput with no
  // bubble on simultaneous accept.
  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == RUN) && out_free;
  assign in_fire  = in_valid && in_ready;
  assign acc      = {1'b0, in_sum} + {{(SUM_W + 1 - CARRY_W){1'b0}}, carry};

`ifdef COL_NORM_LEN_CHECK_EN
  localparam logic [6:0] LAST_COL = 7'(N_COLS - 1);

  logic [6:0] col_count;
  logic       at_last_col;
  logic       len_err_q;

  assign at_last_col = (col_count == LAST_COL);
  // Reaching the last column ends the frame even without in_last.
  assign end_frame   = in_last || at_last_col;
  assign len_err     = len_err_q;

  // Column counter and sticky framing error. A mismatch between in_last and
  // the last-column position is an error in either direction, so the check
  // reduces to an inequality. The counter clears when the flush digit loads.
  always_ff @(posedge clk_sq) begin
    if (reset_sq) begin
      col_count <= '0;
      len_err_q <= 1'b0;
    end else begin
      if (state == FLUSH && out_free) begin
        col_count <= '0;
      end else if (in_fire) begin
        col_count <= col_count + 7'd1;
      end
      if (in_fire && (in_last != at_last_col)) begin
        len_err_q <= 1'b1;
      end
    end
  end
`else
  assign end_frame = in_last;
  assign len_err   = 1'b0;
`endif

  // Main datapath and frame FSM. RUN normalizes one column per accepted beat.
  // FLUSH waits for a free output register, then emits the residual carry as
  // the final digit. The flush digit is emitted even when the carry is zero,
  // so downstream always sees a fixed frame length. The carry is cleared for
  // the next frame. A reset mid-frame drops the partial frame silently.
  always_ff @(posedge clk_sq) begin
    if (reset_sq) begin
      state     <= RUN;
      carry     <= '0;
      out_valid <= 1'b0;
      out_digit <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        RUN: begin
          if (in_fire) begin
            out_digit <= acc[DIGIT_W-1:0];
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            carry     <= acc[SUM_W:DIGIT_W];
            if (end_frame) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            out_digit <= {{(DIGIT_W - CARRY_W){1'b0}}, carry};
            out_last  <= 1'b1;
            out_valid <= 1'b1;
            carry     <= '0;
            state     <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_col_sum_norm_16.sv
// ---------------------------------------------------------------------------
// tb_col_sum_norm_16
//
// Directed testbench for col_sum_norm_16 with N_COLS=66.
// Short frames use in_last. The full-length frames cover the framing check.
// Expected digits are computed by hand and queued. A negedge monitor pops
// the queue on every output handshake, and it also checks that a stalled
// output holds steady and blocks input.
// ---------------------------------------------------------------------------
module tb_col_sum_norm_16;

  localparam int SUM_W   = 26;
  localparam int DIGIT_W = 16;
  localparam int N_COLS  = 66;

`ifdef COL_NORM_LEN_CHECK_EN
  localparam logic LEN_ON = 1'b1;
`else
  localparam logic LEN_ON = 1'b0;
`endif

  logic               clk_sq    = 1'b0;
  logic               reset_sq  = 1'b1;
  logic               in_valid  = 1'b0;
  logic               in_last   = 1'b0;
  logic               out_ready = 1'b1;
  logic [SUM_W-1:0]   in_sum    = '0;
  logic               in_ready;
  logic               out_valid;
  logic [DIGIT_W-1:0] out_digit;
  logic               out_last;
  logic               len_err;

  int          n_checks     = 0;
  int          n_fail       = 0;
  int          stall_cycles = 0;
  logic [16:0] exp_q[$];
  logic        prev_stall   = 1'b0;
  logic [16:0] prev_word    = '0;
  logic [3:0]  ready_pat    = 4'b1001;

  col_sum_norm_16 #(
    .SUM_W  (SUM_W),
    .DIGIT_W(DIGIT_W),
    .N_COLS (N_COLS)
  ) dut (
    .clk_sq   (clk_sq),
    .reset_sq (reset_sq),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_digit(out_digit),
    .out_last (out_last),
    .len_err  (len_err)
  );

  // 10 ns clock
  always #5 clk_sq = ~clk_sq;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_sq);
    #1;
  endtask

  // Present one column sum and hold it until accepted (bounded wait)
  task automatic applyStimulus(input logic [SUM_W-1:0] s, input logic l);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_sum   = s;
    in_last  = l;
    @(negedge clk_sq);
    while (!in_ready && guard < 100) begin
      guard++;
      @(negedge clk_sq);
    end
    if (guard >= 100) checkOutput("in_ready_timeout", 32'(guard), 32'd0);
    cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_sum   = '0;
  endtask

  task automatic waitDrain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      cycle();
      guard++;
    end
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic doReset();
    reset_sq = 1'b1;
    cycle();
    cycle();
    reset_sq = 1'b0;
  endtask

  task automatic pushDigit(input logic l, input logic [15:0] d);
    exp_q.push_back({l, d});
  endtask

  // Output monitor: scoreboard pop on handshake, stall stability, input block
  always @(negedge clk_sq) begin
    if (in_valid && !in_ready) stall_cycles++;
    if (prev_stall)
      checkOutput("hold_digit", 32'({out_valid, out_last, out_digit}), 32'({1'b1, prev_word}));
    if (out_valid && !out_ready)
      checkOutput("no_accept_while_full", 32'(in_ready), 32'd0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0)
        checkOutput("extra_digit", 32'({out_last, out_digit}) | 32'h8000_0000, 32'(exp_q.size()));
      else
        checkOutput("digit", 32'({out_last, out_digit}), 32'(exp_q.pop_front()));
    end
    prev_stall = out_valid && !out_ready;
    prev_word  = {out_last, out_digit};
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    doReset();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_digit", 32'(out_digit), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_len_err", 32'(len_err), 32'd0);

    // Single 3-column frame with large carries.
    // 3FFFFFF -> FFFF c3FF; 3FFFFFF+3FF=40003FE -> 03FE c400;
    // 1+400=401 -> 0401 c000; flush 0000.
    $display("[TB] single frame");
    out_ready = 1'b1;
    pushDigit(1'b0, 16'hFFFF);
    pushDigit(1'b0, 16'h03FE);
    pushDigit(1'b0, 16'h0401);
    pushDigit(1'b1, 16'h0000);
    applyStimulus(26'h3FFFFFF, 1'b0);
    checkOutput("latency_valid", 32'(out_valid), 32'd1);
    checkOutput("latency_digit", 32'(out_digit), 32'h0000FFFF);
    applyStimulus(26'h3FFFFFF, 1'b0);
    applyStimulus(26'h0000001, 1'b1);
    cycle();
    checkOutput("flush_valid", 32'(out_valid), 32'd1);
    checkOutput("flush_last", 32'(out_last), 32'd1);
    waitDrain("drain_single");

    // Back-to-back frames of 0x10000: digits 0,1,1, flush 1, carry restarts
    $display("[TB] back-to-back frames");
    stall_cycles = 0;
    for (int f = 0; f < 2; f++) begin
      pushDigit(1'b0, 16'h0000);
      pushDigit(1'b0, 16'h0001);
      pushDigit(1'b0, 16'h0001);
      pushDigit(1'b1, 16'h0001);
    end
    for (int i = 0; i < 6; i++) applyStimulus(26'h0010000, (i == 2) || (i == 5));
    waitDrain("drain_b2b");
    checkOutput("bubble_count", 32'(stall_cycles), 32'd1);

    // Backpressure with out_ready 1,0,0,1.
    // 12345 -> 2345 c1; ABCDE+1 -> BCDF cA; 1FFFFFF+A=2000009 -> 0009 c200.
    $display("[TB] backpressure");
    pushDigit(1'b0, 16'h2345);
    pushDigit(1'b0, 16'hBCDF);
    pushDigit(1'b0, 16'h0009);
    pushDigit(1'b1, 16'h0200);
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          out_ready = ready_pat[i % 4];
          cycle();
        end
        out_ready = 1'b1;
      end
      begin
        applyStimulus(26'h0012345, 1'b0);
        applyStimulus(26'h00ABCDE, 1'b0);
        applyStimulus(26'h1FFFFFF, 1'b1);
      end
    join
    waitDrain("drain_backpressure");

    // Reset after two columns: partial frame dropped, no stale carry
    $display("[TB] reset mid-frame");
    pushDigit(1'b0, 16'hFFFF);
    pushDigit(1'b0, 16'h03FE);
    applyStimulus(26'h3FFFFFF, 1'b0);
    applyStimulus(26'h3FFFFFF, 1'b0);
    reset_sq = 1'b1;
    cycle();
    reset_sq = 1'b0;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_queue", 32'(exp_q.size()), 32'd0);
    pushDigit(1'b0, 16'h0005);
    pushDigit(1'b1, 16'h0000);
    applyStimulus(26'h0000005, 1'b1);
    checkOutput("post_reset_digit", 32'(out_digit), 32'h5);
    waitDrain("drain_post_reset");

    // in_last on beat 10 of a 66-column frame
    $display("[TB] early in_last");
    doReset();
    checkOutput("len_err_cleared", 32'(len_err), 32'd0);
    for (int i = 0; i < 11; i++) pushDigit(1'b0, 16'h0000);
    pushDigit(1'b1, 16'h0000);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(26'h0, i == 10);
      if (i == 9) checkOutput("len_err_before", 32'(len_err), 32'd0);
    end
    checkOutput("len_err_early", 32'(len_err), 32'(LEN_ON));
    waitDrain("drain_early");
    checkOutput("len_err_sticky", 32'(len_err), 32'(LEN_ON));

    // 66 beats with no in_last: forced flush only when length checking is on
    $display("[TB] missing in_last");
    doReset();
    for (int i = 0; i < N_COLS; i++) pushDigit(1'b0, 16'h0000);
    if (LEN_ON) pushDigit(1'b1, 16'h0000);
    for (int i = 0; i < N_COLS; i++) applyStimulus(26'h0, 1'b0);
    @(negedge clk_sq);
    checkOutput("forced_flush_ready", 32'(in_ready), 32'(!LEN_ON));
    checkOutput("len_err_missing_last", 32'(len_err), 32'(LEN_ON));
    waitDrain("drain_missing_last");
    pushDigit(1'b0, 16'h0000);
    pushDigit(1'b1, 16'h0000);
    applyStimulus(26'h0, 1'b1);
    waitDrain("drain_close");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
